// File: rtl/cpu_mem_arbiter.sv
// Merges the core's instruction-fetch and load/store channels onto one
// single-port memory, one transaction in flight, read data buffered.
module cpu_mem_arbiter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          PC,
  input  logic                 Inst_Req_Valid,
  output logic                 Inst_Req_Ready,
  output logic [31:0]          Instruction,
  output logic                 Inst_Valid,
  input  logic                 Inst_Ready,
  input  logic [31:0]          Address,
  input  logic                 MemWrite,
  input  logic [31:0]          Write_data,
  input  logic [3:0]           Write_strb,
  input  logic                 MemRead,
  output logic                 Mem_Req_Ready,
  output logic [31:0]          Read_data,
  output logic                 Read_data_Valid,
  input  logic                 Read_data_Ready,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [31:0]          mem_req_addr,
  output logic                 mem_req_wen,
  output logic [31:0]          mem_req_wdata,
  output logic [3:0]           mem_req_wstrb,
  input  logic                 mem_resp_valid,
  output logic                 mem_resp_ready,
  input  logic [31:0]          mem_resp_rdata,
  output logic [CNT_WIDTH-1:0] fetch_cnt,
  output logic [CNT_WIDTH-1:0] mem_busy_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SRC_INST, SRC_DRD, SRC_DWR} src_t;

  state_t      state;
  src_t        src;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] resp_buf;

  logic is_idle, data_req, grant_d, grant_i;

  // Data channel wins in IDLE; rst gating keeps the grants low during reset.
  assign is_idle  = (state == IDLE);
  assign data_req = MemRead | MemWrite;
  assign grant_d  = rst & is_idle & data_req;
  assign grant_i  = rst & is_idle & ~data_req & Inst_Req_Valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      src          <= SRC_INST;
      req_addr     <= '0;
      req_wdata    <= '0;
      req_wstrb    <= '0;
      resp_buf     <= '0;
      fetch_cnt    <= '0;
      mem_busy_cnt <= '0;
    end else begin
      if (state != IDLE) mem_busy_cnt <= mem_busy_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (grant_d) begin
            req_addr  <= Address;
            req_wdata <= Write_data;
            req_wstrb <= Write_strb;
            src       <= MemWrite ? SRC_DWR : SRC_DRD;
            state     <= REQ;
          end else if (grant_i) begin
            req_addr  <= PC;
            req_wstrb <= '0;
            src       <= SRC_INST;
            fetch_cnt <= fetch_cnt + 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) state <= (src == SRC_DWR) ? IDLE : WAIT;
        end
        WAIT: begin
          if (mem_resp_valid) begin
            resp_buf <= mem_resp_rdata;
            state    <= RESP;
          end
        end
        RESP: begin
          if ((src == SRC_INST && Inst_Ready) ||
              (src == SRC_DRD && Read_data_Ready)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Inst_Req_Ready  = grant_i;
  assign Mem_Req_Ready   = grant_d;

  assign mem_req_valid   = (state == REQ);
  assign mem_req_addr    = req_addr;
  assign mem_req_wdata   = req_wdata;
  assign mem_req_wen     = mem_req_valid & (src == SRC_DWR);
  assign mem_req_wstrb   = mem_req_wen ? req_wstrb : 4'b0000;
  assign mem_resp_ready  = (state == WAIT);

  // Response data is only presented while its valid is up.
  assign Inst_Valid      = (state == RESP) & (src == SRC_INST);
  assign Instruction     = Inst_Valid ? resp_buf : 32'h0;
  assign Read_data_Valid = (state == RESP) & (src == SRC_DRD);
  assign Read_data       = Read_data_Valid ? resp_buf : 32'h0;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter (CNT_WIDTH=4 so counter wrap is reachable).
module tb_cpu_mem_arbiter;
  localparam int CW = 4;

  logic          clk = 0, rst = 0;
  logic [31:0]   PC = 0, Address = 0, Write_data = 0, mem_resp_rdata = 0;
  logic          Inst_Req_Valid = 0, Inst_Ready = 0, MemWrite = 0, MemRead = 0;
  logic          Read_data_Ready = 0, mem_req_ready = 0, mem_resp_valid = 0;
  logic [3:0]    Write_strb = 0;
  logic          Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid;
  logic          mem_req_valid, mem_req_wen, mem_resp_ready;
  logic [31:0]   Instruction, Read_data, mem_req_addr, mem_req_wdata;
  logic [3:0]    mem_req_wstrb;
  logic [CW-1:0] fetch_cnt, mem_busy_cnt;

  int checks = 0, failures = 0;
  logic [CW-1:0] exp_fetch = 0, exp_busy = 0;

  cpu_mem_arbiter #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .PC(PC), .Inst_Req_Valid(Inst_Req_Valid),
    .Inst_Req_Ready(Inst_Req_Ready), .Instruction(Instruction),
    .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Address(Address),
    .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_resp_rdata(mem_resp_rdata), .fetch_cnt(fetch_cnt),
    .mem_busy_cnt(mem_busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs checked 1 unit later.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Full zero-wait fetch: grant, accept, response, consume.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] data, input bit full);
    PC = pc; Inst_Req_Valid = 1; settle();
    if (full) chk("fetch_grant", {31'b0, Inst_Req_Ready}, 1);
    step(); exp_fetch++;
    Inst_Req_Valid = 0; mem_req_ready = 1; settle();
    if (full) begin
      chk("fetch_req_valid", {31'b0, mem_req_valid}, 1);
      chk("fetch_req_addr", mem_req_addr, pc);
      chk("fetch_req_wen", {31'b0, mem_req_wen}, 0);
      chk("fetch_ready_low", {31'b0, Inst_Req_Ready}, 0);
    end
    step(); exp_busy++;
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = data; settle();
    if (full) chk("fetch_resp_ready", {31'b0, mem_resp_ready}, 1);
    step(); exp_busy++;
    mem_resp_valid = 0; Inst_Ready = 1; settle();
    chk("fetch_inst_valid", {31'b0, Inst_Valid}, 1);
    chk("fetch_instruction", Instruction, data);
    if (full) chk("fetch_no_rd_valid", {31'b0, Read_data_Valid}, 0);
    step(); exp_busy++;
    Inst_Ready = 0; settle();
    if (full) chk("fetch_done_valid", {31'b0, Inst_Valid}, 0);
  endtask

  initial begin
    #2; settle();
    chk("rst_req_valid", {31'b0, mem_req_valid}, 0);
    chk("rst_fetch_cnt", {28'b0, fetch_cnt}, 0);
    chk("rst_busy_cnt", {28'b0, mem_busy_cnt}, 0);
    chk("rst_instruction", Instruction, 0);
    rst = 1;
    step();

    // Fetch with zero-wait memory
    fetch(32'h10, 32'h13, 1);
    chk("f1_fetch_cnt", {28'b0, fetch_cnt}, 1);
    chk("f1_busy_cnt", {28'b0, mem_busy_cnt}, 3);

    // Store with mem_req_ready delayed two cycles
    MemWrite = 1; Address = 32'h100; Write_data = 32'hDEADBEEF; Write_strb = 4'b0011; settle();
    chk("st_grant", {31'b0, Mem_Req_Ready}, 1);
    chk("st_no_inst_grant", {31'b0, Inst_Req_Ready}, 0);
    step();
    MemWrite = 0; Address = 0; Write_data = 0; Write_strb = 0;
    for (int i = 0; i < 3; i++) begin
      mem_req_ready = (i == 2); settle();
      chk("st_req_valid", {31'b0, mem_req_valid}, 1);
      chk("st_addr", mem_req_addr, 32'h100);
      chk("st_wdata", mem_req_wdata, 32'hDEADBEEF);
      chk("st_wstrb", {28'b0, mem_req_wstrb}, 4'b0011);
      chk("st_wen", {31'b0, mem_req_wen}, 1);
      chk("st_no_rd_valid", {31'b0, Read_data_Valid}, 0);
      step(); exp_busy++;
    end
    mem_req_ready = 0; settle();
    chk("st_idle_req", {31'b0, mem_req_valid}, 0);
    chk("st_idle_resp_ready", {31'b0, mem_resp_ready}, 0);
    chk("st_idle_rd_valid", {31'b0, Read_data_Valid}, 0);
    chk("st_busy_cnt", {28'b0, mem_busy_cnt}, {28'b0, exp_busy});

    // Load with four cycles of Read_data_Ready backpressure
    MemRead = 1; Address = 32'h200; Write_strb = 4'b1111; settle();
    chk("ld_grant", {31'b0, Mem_Req_Ready}, 1);
    step();
    MemRead = 0; Write_strb = 0; mem_req_ready = 1; settle();
    chk("ld_addr", mem_req_addr, 32'h200);
    chk("ld_wen", {31'b0, mem_req_wen}, 0);
    chk("ld_wstrb", {28'b0, mem_req_wstrb}, 0);
    step(); exp_busy++;
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h12345678;
    step(); exp_busy++;
    mem_resp_valid = 0; mem_resp_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      Read_data_Ready = (i == 4); settle();
      chk("ld_rd_valid", {31'b0, Read_data_Valid}, 1);
      chk("ld_rd_data", Read_data, 32'h12345678);
      chk("ld_no_inst_valid", {31'b0, Inst_Valid}, 0);
      step(); exp_busy++;
    end
    Read_data_Ready = 0; settle();
    chk("ld_done_valid", {31'b0, Read_data_Valid}, 0);
    chk("ld_busy_cnt", {28'b0, mem_busy_cnt}, {28'b0, exp_busy});

    // Simultaneous load and fetch: data first
    MemRead = 1; Address = 32'h300; Inst_Req_Valid = 1; PC = 32'h44; settle();
    chk("pri_mem_grant", {31'b0, Mem_Req_Ready}, 1);
    chk("pri_inst_held", {31'b0, Inst_Req_Ready}, 0);
    step();
    MemRead = 0; mem_req_ready = 1; settle();
    chk("pri_req_addr", mem_req_addr, 32'h300);
    chk("pri_inst_req_busy", {31'b0, Inst_Req_Ready}, 0);
    step(); exp_busy++;
    mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'hA5A5A5A5;
    step(); exp_busy++;
    mem_resp_valid = 0; Read_data_Ready = 1; settle();
    chk("pri_rd_data", Read_data, 32'hA5A5A5A5);
    chk("pri_inst_req_resp", {31'b0, Inst_Req_Ready}, 0);
    step(); exp_busy++;
    Read_data_Ready = 0;
    fetch(32'h44, 32'h00500093, 1);
    chk("pri_fetch_cnt", {28'b0, fetch_cnt}, {28'b0, exp_fetch});

    // Reset asserted while waiting for a fetch response
    PC = 32'h80; Inst_Req_Valid = 1;
    step();
    Inst_Req_Valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; settle();
    chk("rw_in_wait", {31'b0, mem_resp_ready}, 1);
    rst = 0; settle();
    chk("rw_resp_ready", {31'b0, mem_resp_ready}, 0);
    chk("rw_req_valid", {31'b0, mem_req_valid}, 0);
    chk("rw_req_addr", mem_req_addr, 0);
    chk("rw_fetch_cnt", {28'b0, fetch_cnt}, 0);
    chk("rw_busy_cnt", {28'b0, mem_busy_cnt}, 0);
    step();
    rst = 1; exp_fetch = 0; exp_busy = 0;
    fetch(32'h20, 32'h00000073, 1);
    chk("rr_fetch_cnt", {28'b0, fetch_cnt}, 1);
    chk("rr_busy_cnt", {28'b0, mem_busy_cnt}, 3);

    // Sixteen more fetches: 17 total since reset wraps a 4-bit counter to 1
    for (int i = 0; i < 16; i++) fetch(32'h1000 + 4 * i, 32'h100 + i, 0);
    chk("wrap_fetch_cnt", {28'b0, fetch_cnt}, 1);
    chk("wrap_busy_cnt", {28'b0, mem_busy_cnt}, 3);
    chk("wrap_model_busy", {28'b0, mem_busy_cnt}, {28'b0, exp_busy});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
